spi_sram_controller: RTL and testbench
======================================

SPI_SRAM_CONTROLLER -- requirements
Module: spi_sram_controller

Interface
REQ-001 SHALL have parameter READ_CMD, default 8'h03, meaning the SPI opcode sent for a word read.
REQ-002 SHALL have parameter WRITE_CMD, default 8'h02, meaning the SPI opcode sent for a word write.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port request, input, 1 bit: core pulse requesting one word transfer.
REQ-006 SHALL have port request_type, input, 1 bit: 0 = read, 1 = write.
REQ-007 SHALL have port request_address, input, 16 bits: word address.
REQ-008 SHALL have port data_out, input, 16 bits: write data from core.
REQ-009 SHALL have port memory_in, output, 16 bits: read data to core.
REQ-010 SHALL have port memory_ready, output, 1 bit: read-complete pulse.
REQ-011 SHALL have port write_complete, output, 1 bit: write-complete pulse.
REQ-012 SHALL have port memory_critical, output, 1 bit: pulse flagging a dropped request.
REQ-013 SHALL have ports spi_cs_n, spi_sck and spi_mosi, outputs, 1 bit each, plus spi_miso, input, 1 bit: SPI mode-0 link to an external 24-bit-address SRAM in sequential mode.

Function
REQ-014 SHALL implement states IDLE, SHIFT and DONE.
REQ-015 In IDLE with request=1 at a posedge, SHALL latch request_type, request_address and data_out, then enter SHIFT.
REQ-016 SHALL form the 48-bit frame, sent MSB first: opcode (READ_CMD or WRITE_CMD) ‖ byte address {7'b0, request_address, 1'b0} ‖ 16 data bits.
REQ-017 Data bits SHALL be data_out[15:0] for a write and don't-care (drive 0) for a read.
REQ-018 spi_cs_n SHALL be 0 exactly in SHIFT cycles and 1 otherwise.
REQ-019 Each bit SHALL take 2 clk cycles: phase A with spi_sck=0 and spi_mosi=current bit, then phase B with spi_sck=1 and spi_mosi held.
REQ-020 spi_miso SHALL be sampled at the posedge ending phase B; only the last 16 bit-slots are shifted into the read register.
REQ-021 SHIFT SHALL last exactly 96 cycles, using a 7-bit counter 0..95; the counter SHALL NOT wrap, and at 95 the block enters DONE.
REQ-022 DONE SHALL last 1 cycle with spi_cs_n=1 and spi_sck=0, asserting memory_ready=1 (read) or write_complete=1 (write), never both; the block then returns to IDLE.
REQ-023 Latency: with the request accepted at edge T0, the completion pulse SHALL be high in the cycle following edge T0+97.
REQ-024 On read DONE, memory_in SHALL update to the assembled word (first received byte = [15:8]) and hold until the next read's DONE; a write SHALL NOT change memory_in.
REQ-025 request=1 while in SHIFT or DONE SHALL be ignored, leaving the transfer undisturbed, and SHALL pulse memory_critical=1 for one cycle.
REQ-026 Request inputs SHALL be sampled only on acceptance; input changes during SHIFT SHALL NOT affect the frame.
REQ-027 A back-to-back request arriving in the first IDLE cycle after DONE SHALL be accepted normally.
REQ-028 spi_sck SHALL idle at 0 and spi_mosi SHALL idle at 0 outside SHIFT.

Reset
REQ-029 reset_n=0 SHALL immediately, without waiting for a clock edge, force: state IDLE; spi_cs_n=1; spi_sck=0; spi_mosi=0; memory_in=16'h0000; memory_ready=0; write_complete=0; memory_critical=0; counter and latches 0.
REQ-030 Reset mid-SHIFT SHALL abort the frame (cs_n rising at once) with no completion pulse; the first request after reset_n rises SHALL be accepted in IDLE.

Verification
REQ-031 Write 16'hBEEF to word 16'h0012 -> MOSI frame 02_000024_BEEF; cs_n low for 96 cycles; write_complete pulse at T0+97; memory_ready stays 0.
REQ-032 Read word 16'h0012 with SRAM model returning BE,EF -> frame 03_000024_xxxx; memory_in=16'hBEEF with a one-cycle memory_ready at T0+97.
REQ-033 Request during SHIFT bit 20 -> memory_critical one-cycle pulse; the original transfer completes unchanged; no second transfer starts.
REQ-034 reset_n low at SHIFT cycle 40 -> cs_n=1 and outputs at reset values asynchronously; no completion pulse; a subsequent read completes correctly.
REQ-035 Back-to-back read 16'hFFFF then write 16'h0000 with request in the first IDLE cycle -> byte addresses 01FFFE and 000000; both accepted; memory_critical never asserted.
REQ-036 Sample SCK/MOSI every cycle -> SCK period = 2 clk; MOSI stable while SCK=1; SCK=0 whenever cs_n=1.

Source files
------------

// File: rtl/spi_sram_controller.sv
// rtl/spi_sram_controller.sv - single-word SPI mode-0 read/write controller for a 24-bit-address SRAM
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   request, request_type        one-cycle transfer request (type 0 = read, 1 = write)
//   request_address, data_out    word address and write data, latched on acceptance
//   memory_in                    last word read from the SRAM
//   memory_ready, write_complete one-cycle completion pulses (read / write)
//   memory_critical              one-cycle pulse when a request arrives while busy and is dropped
//   spi_cs_n, spi_sck, spi_mosi  SPI outputs to the SRAM
//   spi_miso                     SPI input from the SRAM
module spi_sram_controller #(
    parameter logic [7:0] READ_CMD  = 8'h03,
    parameter logic [7:0] WRITE_CMD = 8'h02
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        request,
    input  logic        request_type,
    input  logic [15:0] request_address,
    input  logic [15:0] data_out,
    output logic [15:0] memory_in,
    output logic        memory_ready,
    output logic        write_complete,
    output logic        memory_critical,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 48 bits x 2 clk per bit; the last 16 bit slots carry the data word
    localparam logic [6:0] LAST_CYCLE = 7'd95;
    localparam logic [6:0] DATA_START = 7'd64;

    state_t      state;
    state_t      state_next;
    logic [6:0]  cnt;
    logic [47:0] frame;
    logic        is_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = SHIFT;
            SHIFT:   if (cnt == LAST_CYCLE) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Even counter values are phase A (sck low), odd values phase B (sck high).
    always_comb begin
        spi_cs_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        if (state == SHIFT) begin
            spi_cs_n = 1'b0;
            spi_sck  = cnt[0];
            spi_mosi = frame[47];
        end
    end

    // The frame register doubles as the receive register: MISO bits enter at the
    // bottom as the outgoing frame leaves the top, so after the 48th shift the
    // low 16 bits hold the received word with the first byte in [15:8].
    // Completion and drop flags are registered, so they appear one cycle after
    // the state that produced them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt             <= 7'd0;
            frame           <= 48'd0;
            is_write        <= 1'b0;
            memory_in       <= 16'h0000;
            memory_ready    <= 1'b0;
            write_complete  <= 1'b0;
            memory_critical <= 1'b0;
        end else begin
            memory_critical <= request && (state != IDLE);
            memory_ready    <= (state == DONE) && !is_write;
            write_complete  <= (state == DONE) && is_write;
            case (state)
                IDLE: begin
                    if (request) begin
                        is_write <= request_type;
                        cnt      <= 7'd0;
                        frame    <= {request_type ? WRITE_CMD : READ_CMD,
                                     7'b0, request_address, 1'b0,
                                     request_type ? data_out : 16'h0000};
                    end
                end
                SHIFT: begin
                    if (cnt != LAST_CYCLE) begin
                        cnt <= cnt + 7'd1;
                    end else begin
                        cnt <= 7'd0;
                    end
                    // advance one bit at the edge that ends phase B
                    if (cnt[0]) begin
                        frame <= {frame[46:0], (cnt >= DATA_START) ? spi_miso : 1'b0};
                    end
                end
                DONE: begin
                    if (!is_write) begin
                        memory_in <= frame[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_controller.sv
// tb/tb_spi_sram_controller.sv - directed table-driven bench for spi_sram_controller
module tb_spi_sram_controller;

    logic        clk;
    logic        reset_n;
    logic        request;
    logic        request_type;
    logic [15:0] request_address;
    logic [15:0] data_out;
    logic [15:0] memory_in;
    logic        memory_ready;
    logic        write_complete;
    logic        memory_critical;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    spi_sram_controller #(
        .READ_CMD (8'h03),
        .WRITE_CMD(8'h02)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .request        (request),
        .request_type   (request_type),
        .request_address(request_address),
        .data_out       (data_out),
        .memory_in      (memory_in),
        .memory_ready   (memory_ready),
        .write_complete (write_complete),
        .memory_critical(memory_critical),
        .spi_cs_n       (spi_cs_n),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM model: captures MOSI on SCK rise, drives the response word on SCK fall
    logic [15:0] resp = 16'h0000;
    logic [47:0] cap = 48'd0;
    int          bitcnt = 0;
    logic        s_last_sck = 1'b0;

    initial spi_miso = 1'b0;

    always @(spi_cs_n or spi_sck) begin
        if (!spi_cs_n && spi_sck && !s_last_sck) begin
            cap = {cap[46:0], spi_mosi};
            bitcnt++;
        end else if (!spi_cs_n && !spi_sck && s_last_sck) begin
            if (bitcnt >= 32 && bitcnt < 48) spi_miso = resp[47 - bitcnt];
            else spi_miso = 1'b0;
        end else if (!spi_cs_n && !spi_sck && !s_last_sck) begin
            bitcnt   = 0;
            cap      = 48'd0;
            spi_miso = 1'b0;
        end
        s_last_sck = spi_sck;
    end

    // Per-cycle link and pulse monitor
    int   spi_viol = 0;
    int   both_cnt = 0;
    int   mr_cnt = 0;
    int   wc_cnt = 0;
    int   crit_cnt = 0;
    logic prev_cs_n = 1'b1;
    logic prev_sck = 1'b0;
    logic prev_mosi = 1'b0;

    always @(negedge clk) begin
        if (spi_cs_n && (spi_sck || spi_mosi)) spi_viol++;
        if (!spi_cs_n && prev_cs_n && spi_sck) spi_viol++;
        if (!spi_cs_n && !prev_cs_n && (spi_sck == prev_sck)) spi_viol++;
        if (spi_sck && (spi_mosi !== prev_mosi)) spi_viol++;
        if (memory_ready && write_complete) both_cnt++;
        if (memory_ready) mr_cnt++;
        if (write_complete) wc_cnt++;
        if (memory_critical) crit_cnt++;
        prev_cs_n = spi_cs_n;
        prev_sck  = spi_sck;
        prev_mosi = spi_mosi;
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rsp;
        int          inject_at;
        logic [47:0] frame;
        logic [15:0] mem;
    } vec_t;

    vec_t vecs[7];
    int   exp_rd = 0;
    int   exp_wr = 0;
    int   exp_crit = 0;

    task automatic run_txn(input vec_t v, input int idx);
        int         k;
        int         lows;
        logic       seen;
        logic [1:0] kind;
        string      tag;
        tag = $sformatf("v%0d", idx);
        resp = v.rsp;
        @(negedge clk);
        request         = 1'b1;
        request_type    = v.wr;
        request_address = v.addr;
        data_out        = v.wdata;
        @(posedge clk);
        #1;
        request         = 1'b0;
        request_type    = ~v.wr;
        request_address = ~v.addr;
        data_out        = ~v.wdata;
        lows = (spi_cs_n == 1'b0) ? 1 : 0;
        seen = 1'b0;
        kind = 2'b00;
        k    = 0;
        while (!seen && k < 120) begin
            @(posedge clk);
            #1;
            k++;
            request = 1'b0;
            if (!spi_cs_n) lows++;
            if (memory_ready || write_complete) begin
                seen = 1'b1;
                kind = {memory_ready, write_complete};
            end else if (k == v.inject_at) begin
                request         = 1'b1;
                request_type    = ~v.wr;
                request_address = 16'hDEAD;
                data_out        = 16'hDEAD;
            end
        end
        if (v.wr) exp_wr++;
        else exp_rd++;
        if (v.inject_at >= 0) exp_crit++;
        chk({tag, "_latency"}, k, 97);
        chk({tag, "_pulse_kind"}, kind, {~v.wr, v.wr});
        chk({tag, "_frame"}, {bitcnt[7:0], cap}, {8'd48, v.frame});
        chk({tag, "_cs_low_cycles"}, lows, 96);
        chk({tag, "_memory_in"}, memory_in, v.mem);
    endtask

    initial begin
        //               wr    addr      wdata     rsp       inj  frame                  mem
        vecs[0] = '{1'b1, 16'h0012, 16'hBEEF, 16'h0000, -1, 48'h02_000024_BEEF, 16'h0000};
        vecs[1] = '{1'b0, 16'h0012, 16'h1111, 16'hBEEF, 40, 48'h03_000024_0000, 16'hBEEF};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h5A5A, 16'h1234, -1, 48'h03_01FFFE_0000, 16'h1234};
        vecs[3] = '{1'b1, 16'h0000, 16'hA5C3, 16'hFFFF, -1, 48'h02_000000_A5C3, 16'h1234};
        vecs[4] = '{1'b0, 16'h8001, 16'h0000, 16'h0F0F, 96, 48'h03_010002_0000, 16'h0F0F};
        vecs[5] = '{1'b1, 16'h7FFF, 16'hFFFF, 16'h0000, -1, 48'h02_00FFFE_FFFF, 16'h0F0F};
        vecs[6] = '{1'b0, 16'h0012, 16'h0000, 16'hC3A5, -1, 48'h03_000024_0000, 16'hC3A5};

        reset_n         = 1'b0;
        request         = 1'b0;
        request_type    = 1'b0;
        request_address = 16'h0000;
        data_out        = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {spi_cs_n, spi_sck, spi_mosi, memory_ready, write_complete, memory_critical, memory_in},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        reset_n = 1'b1;

        // back-to-back: each request lands in the first IDLE cycle after the previous DONE
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], i);
        end

        // reset asserted mid-SHIFT at counter value 40, checked before any clock edge
        resp = 16'hCAFE;
        @(negedge clk);
        request         = 1'b1;
        request_type    = 1'b0;
        request_address = 16'h0012;
        @(posedge clk);
        #1;
        request = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_mid_shift",
            {spi_cs_n, spi_sck, spi_mosi, memory_ready, write_complete, memory_critical, memory_in},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("cs_idle_after_reset", spi_cs_n, 1'b1);

        run_txn(vecs[6], 6);

        repeat (5) @(negedge clk);
        chk("read_pulse_total", mr_cnt, exp_rd);
        chk("write_pulse_total", wc_cnt, exp_wr);
        chk("critical_pulse_total", crit_cnt, exp_crit);
        chk("both_pulses_together", both_cnt, 0);
        chk("spi_link_violations", spi_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
